// File: rtl/pipe_block_sched_if.sv
// Host pipe handshake bundle for pipe_block_sched.
// The master side drives FIFO counts, requests, strobes and the stream enable.
// The slave side (the scheduler) returns ready flags, grants, counters and the error flag.
interface pipe_block_sched_if;
  logic [9:0]  pipe_in_wr_count;
  logic [9:0]  pipe_out_rd_count;
  logic        host_in_req;
  logic        host_out_req;
  logic        pipe_in_strobe;
  logic        pipe_out_strobe;
  logic        stream_go;
  logic        pipe_in_ready;
  logic        pipe_out_ready;
  logic        grant_in;
  logic        grant_out;
  logic        stream_en;
  logic [15:0] blocks_in;
  logic [15:0] blocks_out;
  logic        proto_err;

  modport master (
    output pipe_in_wr_count, pipe_out_rd_count, host_in_req, host_out_req,
           pipe_in_strobe, pipe_out_strobe, stream_go,
    input  pipe_in_ready, pipe_out_ready, grant_in, grant_out, stream_en,
           blocks_in, blocks_out, proto_err
  );

  modport slave (
    input  pipe_in_wr_count, pipe_out_rd_count, host_in_req, host_out_req,
           pipe_in_strobe, pipe_out_strobe, stream_go,
    output pipe_in_ready, pipe_out_ready, grant_in, grant_out, stream_en,
           blocks_in, blocks_out, proto_err
  );
endinterface

// File: rtl/pipe_block_sched.sv
// Block-level scheduler for host pipe-in / pipe-out transfers.
// It grants one whole block at a time to whichever side has both a request
// and FIFO room/data, and it alternates between the sides when both compete.
// It also throttles the pattern stream with a hysteresis band on the output FIFO level.
module pipe_block_sched #(
  parameter int IN_DEPTH    = 1024,
  parameter int OUT_DEPTH   = 256,
  parameter int BLOCK_WORDS = 128,
  parameter int STREAM_HWM  = 224,
  parameter int STREAM_LWM  = 192
) (
  input logic          okClk,
  input logic          reset,
  pipe_block_sched_if.slave bus
);
  localparam int WCW = $clog2(BLOCK_WORDS);
  localparam logic [WCW-1:0] LAST_WORD  = WCW'(BLOCK_WORDS - 1);
  localparam logic [31:0]    IN_LIMIT   = 32'(IN_DEPTH - BLOCK_WORDS);
  localparam logic [31:0]    OUT_BLOCK  = 32'(BLOCK_WORDS);
  localparam logic [31:0]    HWM        = 32'(STREAM_HWM);
  localparam logic [31:0]    LWM        = 32'(STREAM_LWM);
  localparam logic           SERVED_IN  = 1'b1;
  localparam logic           SERVED_OUT = 1'b0;

  // Parameter sanity: a block and the stream marks must fit in the output FIFO.
  if (BLOCK_WORDS < 2 || BLOCK_WORDS > OUT_DEPTH || STREAM_HWM > OUT_DEPTH ||
      STREAM_LWM > STREAM_HWM) begin : g_bad_params
    $error("pipe_block_sched: inconsistent FIFO/block/stream parameters");
  end

  typedef enum logic [1:0] {IDLE, IN_XFER, OUT_XFER} state_t;

  state_t         state_q, state_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic           last_served_q, last_served_d;
  logic [15:0]    blocks_in_q, blocks_in_d;
  logic [15:0]    blocks_out_q, blocks_out_d;
  logic           stream_en_q, stream_en_d;
  logic           proto_err_q, proto_err_d;
  logic           in_ready_q, out_ready_q;

  logic [31:0] wr_cnt_ext;
  logic [31:0] rd_cnt_ext;
  logic        in_elig;
  logic        out_elig;

  assign wr_cnt_ext = 32'(bus.pipe_in_wr_count);
  assign rd_cnt_ext = 32'(bus.pipe_out_rd_count);
  assign in_elig    = bus.host_in_req  & in_ready_q;
  assign out_elig   = bus.host_out_req & out_ready_q;

  // State register plus all scheduler bookkeeping; reset returns to a clean IDLE.
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      word_cnt_q    <= '0;
      last_served_q <= SERVED_OUT;
      blocks_in_q   <= '0;
      blocks_out_q  <= '0;
      stream_en_q   <= 1'b0;
      proto_err_q   <= 1'b0;
      in_ready_q    <= 1'b0;
      out_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      last_served_q <= last_served_d;
      blocks_in_q   <= blocks_in_d;
      blocks_out_q  <= blocks_out_d;
      stream_en_q   <= stream_en_d;
      proto_err_q   <= proto_err_d;
      in_ready_q    <= (wr_cnt_ext <= IN_LIMIT);
      out_ready_q   <= (rd_cnt_ext >= OUT_BLOCK);
    end
  end

  // Next-state: arbitration in IDLE, word counting in the XFER states, stray-strobe flagging.
  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    last_served_d = last_served_q;
    blocks_in_d   = blocks_in_q;
    blocks_out_d  = blocks_out_q;
    proto_err_d   = proto_err_q;

    // A strobe that does not belong to the current transfer is never counted.
    if ((bus.pipe_in_strobe  && state_q != IN_XFER) ||
        (bus.pipe_out_strobe && state_q != OUT_XFER)) begin
      proto_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        word_cnt_d = '0;
        if (in_elig && out_elig) begin
          state_d = (last_served_q == SERVED_OUT) ? IN_XFER : OUT_XFER;
        end else if (in_elig) begin
          state_d = IN_XFER;
        end else if (out_elig) begin
          state_d = OUT_XFER;
        end
      end
      IN_XFER: begin
        if (bus.pipe_in_strobe) begin
          if (word_cnt_q == LAST_WORD) begin
            state_d       = IDLE;
            word_cnt_d    = '0;
            blocks_in_d   = blocks_in_q + 16'd1;
            last_served_d = SERVED_IN;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      OUT_XFER: begin
        if (bus.pipe_out_strobe) begin
          if (word_cnt_q == LAST_WORD) begin
            state_d       = IDLE;
            word_cnt_d    = '0;
            blocks_out_d  = blocks_out_q + 16'd1;
            last_served_d = SERVED_OUT;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        word_cnt_d = '0;
      end
    endcase
  end

  // Stream throttle: clearing wins, setting only below the low mark, hold in between.
  always_comb begin
    stream_en_d = stream_en_q;
    if (!bus.stream_go || rd_cnt_ext >= HWM) begin
      stream_en_d = 1'b0;
    end else if (rd_cnt_ext < LWM) begin
      stream_en_d = 1'b1;
    end
  end

  // Outputs: grants decoded straight from the state register, the rest mirror registers.
  always_comb begin
    bus.grant_in       = (state_q == IN_XFER);
    bus.grant_out      = (state_q == OUT_XFER);
    bus.pipe_in_ready  = in_ready_q;
    bus.pipe_out_ready = out_ready_q;
    bus.stream_en      = stream_en_q;
    bus.blocks_in      = blocks_in_q;
    bus.blocks_out     = blocks_out_q;
    bus.proto_err      = proto_err_q;
  end
endmodule

// File: tb/tb_pipe_block_sched.sv
// Scoreboard bench for pipe_block_sched: stimulus pushes expected grants,
// block completions and status values; a negedge monitor pops and compares.
module tb_pipe_block_sched;
  logic clk;
  logic rst;

  pipe_block_sched_if bus ();

  pipe_block_sched dut (
    .okClk (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int F_IN_RDY  = 0;
  localparam int F_OUT_RDY = 1;
  localparam int F_GIN     = 2;
  localparam int F_GOUT    = 3;
  localparam int F_STREAM  = 4;
  localparam int F_PERR    = 5;
  localparam int F_BIN     = 6;
  localparam int F_BOUT    = 7;

  typedef struct {
    int    field;
    int    exp;
    string name;
  } chk_t;

  typedef struct {
    int bin;
    int bout;
  } done_t;

  chk_t  status_q[$];
  done_t done_q[$];
  int    grant_q[$];   // 1 = IN, 2 = OUT

  int n_cmp;
  int n_bad;

  task automatic compare(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int read_field(input int f);
    case (f)
      F_IN_RDY:  return int'(bus.pipe_in_ready);
      F_OUT_RDY: return int'(bus.pipe_out_ready);
      F_GIN:     return int'(bus.grant_in);
      F_GOUT:    return int'(bus.grant_out);
      F_STREAM:  return int'(bus.stream_en);
      F_PERR:    return int'(bus.proto_err);
      F_BIN:     return int'(bus.blocks_in);
      F_BOUT:    return int'(bus.blocks_out);
      default:   return -1;
    endcase
  endfunction

  task automatic chk(input int field, input int exp, input string name);
    chk_t c;
    c.field = field;
    c.exp   = exp;
    c.name  = name;
    status_q.push_back(c);
  endtask

  task automatic push_done(input int bin, input int bout);
    done_t d;
    d.bin  = bin;
    d.bout = bout;
    done_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic in_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pipe_in_strobe = 1'b1;
      tick();
    end
    bus.pipe_in_strobe = 1'b0;
  endtask

  task automatic out_strobes(input int n);
    for (int i = 0; i < n; i++) begin
      bus.pipe_out_strobe = 1'b1;
      tick();
    end
    bus.pipe_out_strobe = 1'b0;
  endtask

  // Monitor: status checks, grant starts (kind + idle gap) and block completions.
  initial begin : monitor
    logic  prev_gin;
    logic  prev_gout;
    int    kind;
    chk_t  c;
    done_t d;
    prev_gin  = 1'b0;
    prev_gout = 1'b0;
    forever begin
      @(negedge clk);
      while (status_q.size() > 0) begin
        c = status_q.pop_front();
        compare(c.name, read_field(c.field), c.exp);
      end
      if (!rst) begin
        if ((bus.grant_in && !prev_gin) || (bus.grant_out && !prev_gout)) begin
          kind = (bus.grant_in && bus.grant_out) ? 3 : (bus.grant_in ? 1 : 2);
          $display("grant start: %s at t=%0t", (kind == 1) ? "IN" : (kind == 2) ? "OUT" : "BOTH", $time);
          if (grant_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_grant: got kind %0d, expected none", kind);
          end else begin
            compare("grant_kind", kind, grant_q.pop_front());
          end
          compare("idle_gap", int'(prev_gin | prev_gout), 0);
        end
        if ((!bus.grant_in && prev_gin) || (!bus.grant_out && prev_gout)) begin
          $display("block done: blocks_in=%0d blocks_out=%0d at t=%0t", bus.blocks_in, bus.blocks_out, $time);
          if (done_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got completion, expected none");
          end else begin
            d = done_q.pop_front();
            compare("done_blocks_in", int'(bus.blocks_in), d.bin);
            compare("done_blocks_out", int'(bus.blocks_out), d.bout);
          end
        end
      end
      prev_gin  = bus.grant_in;
      prev_gout = bus.grant_out;
    end
  end

  // Stimulus: directed scenarios with hand-computed expectations.
  initial begin : stim
    n_cmp = 0;
    n_bad = 0;
    rst                   = 1'b1;
    bus.pipe_in_wr_count  = 10'd0;
    bus.pipe_out_rd_count = 10'd0;
    bus.host_in_req       = 1'b0;
    bus.host_out_req      = 1'b0;
    bus.pipe_in_strobe    = 1'b0;
    bus.pipe_out_strobe   = 1'b0;
    bus.stream_go         = 1'b0;
    tick();
    tick();

    // Reset state
    chk(F_GIN, 0, "rst_grant_in");
    chk(F_GOUT, 0, "rst_grant_out");
    chk(F_IN_RDY, 0, "rst_in_ready");
    chk(F_OUT_RDY, 0, "rst_out_ready");
    chk(F_STREAM, 0, "rst_stream_en");
    chk(F_PERR, 0, "rst_proto_err");
    chk(F_BIN, 0, "rst_blocks_in");
    chk(F_BOUT, 0, "rst_blocks_out");
    tick();

    // Single pipe-in: grant two edges after reset release
    rst = 1'b0;
    bus.host_in_req = 1'b1;
    grant_q.push_back(1);
    push_done(1, 0);
    chk(F_GIN, 0, "p1_grant_before_edge");
    tick();
    chk(F_IN_RDY, 1, "p1_in_ready_edge1");
    chk(F_GIN, 0, "p1_grant_edge1");
    tick();
    chk(F_GIN, 1, "p1_grant_edge2");
    bus.host_in_req = 1'b0;          // deassert mid-transfer: must not abort
    in_strobes(127);
    chk(F_GIN, 1, "p1_grant_after_127");
    in_strobes(1);
    chk(F_GIN, 0, "p1_grant_after_128");
    chk(F_BIN, 1, "p1_blocks_in");

    // Full boundary on the input FIFO
    bus.pipe_in_wr_count = 10'd896;
    tick();
    chk(F_IN_RDY, 1, "bnd_ready_896");
    bus.pipe_in_wr_count = 10'd897;
    tick();
    chk(F_IN_RDY, 0, "bnd_ready_897");
    bus.host_in_req = 1'b1;
    repeat (4) tick();
    chk(F_GIN, 0, "bnd_no_grant_897");
    chk(F_PERR, 0, "bnd_no_proto_err");
    bus.host_in_req = 1'b0;
    bus.pipe_in_wr_count = 10'd0;
    tick();

    // Stray strobes during IN_XFER
    bus.host_in_req = 1'b1;
    grant_q.push_back(1);
    push_done(2, 0);
    tick();
    bus.host_in_req = 1'b0;
    in_strobes(10);
    bus.pipe_out_strobe = 1'b1;       // stray alone
    tick();
    bus.pipe_out_strobe = 1'b0;
    chk(F_PERR, 1, "stray_proto_err");
    chk(F_GIN, 1, "stray_grant_in");
    chk(F_GOUT, 0, "stray_grant_out");
    bus.pipe_in_strobe  = 1'b1;       // both at once: only the IN strobe counts
    bus.pipe_out_strobe = 1'b1;
    tick();
    bus.pipe_in_strobe  = 1'b0;
    bus.pipe_out_strobe = 1'b0;
    in_strobes(116);
    chk(F_GIN, 1, "stray_grant_after_127");
    in_strobes(1);
    chk(F_GIN, 0, "stray_grant_after_128");
    chk(F_BIN, 2, "stray_blocks_in");
    chk(F_PERR, 1, "stray_proto_err_sticky");

    // Stream hysteresis
    bus.stream_go = 1'b1;
    bus.pipe_out_rd_count = 10'd100;
    tick();
    chk(F_STREAM, 1, "stream_rd100");
    chk(F_OUT_RDY, 0, "out_ready_rd100");
    bus.pipe_out_rd_count = 10'd224;
    tick();
    chk(F_STREAM, 0, "stream_rd224");
    bus.pipe_out_rd_count = 10'd200;
    tick();
    chk(F_STREAM, 0, "stream_rd200_hold");
    bus.pipe_out_rd_count = 10'd191;
    tick();
    chk(F_STREAM, 1, "stream_rd191");
    chk(F_OUT_RDY, 1, "out_ready_rd191");
    bus.stream_go = 1'b0;
    tick();
    chk(F_STREAM, 0, "stream_go_off");

    // Reset pulse so last_served starts at OUT again, then contention
    bus.pipe_out_rd_count = 10'd128;
    rst = 1'b1;
    chk(F_PERR, 0, "rst2_proto_err");
    chk(F_BIN, 0, "rst2_blocks_in");
    tick();
    rst = 1'b0;
    tick();
    tick();
    bus.host_in_req  = 1'b1;
    bus.host_out_req = 1'b1;
    grant_q.push_back(1);
    grant_q.push_back(2);
    grant_q.push_back(1);
    push_done(1, 0);
    push_done(1, 1);
    push_done(2, 1);
    tick();
    in_strobes(128);
    chk(F_GIN, 0, "cont_idle1_gin");
    chk(F_GOUT, 0, "cont_idle1_gout");
    tick();
    out_strobes(128);
    chk(F_GIN, 0, "cont_idle2_gin");
    chk(F_GOUT, 0, "cont_idle2_gout");
    tick();
    in_strobes(128);
    bus.host_in_req  = 1'b0;
    bus.host_out_req = 1'b0;
    chk(F_GIN, 0, "cont_end_gin");
    tick();

    // Reset in the middle of a block
    bus.host_in_req = 1'b1;
    grant_q.push_back(1);
    tick();
    in_strobes(50);
    rst = 1'b1;
    chk(F_GIN, 0, "midrst_grant_in");
    chk(F_BIN, 0, "midrst_blocks_in");
    chk(F_IN_RDY, 0, "midrst_in_ready");
    tick();
    rst = 1'b0;
    grant_q.push_back(1);
    push_done(1, 0);
    tick();
    tick();
    chk(F_GIN, 1, "midrst_regrant");
    bus.host_in_req = 1'b0;
    in_strobes(127);
    chk(F_GIN, 1, "midrst_grant_after_127");
    in_strobes(1);
    chk(F_GIN, 0, "midrst_grant_after_128");
    chk(F_BIN, 1, "midrst_blocks_in_final");

    tick();
    tick();
    compare("grant_queue_drained", grant_q.size(), 0);
    compare("done_queue_drained", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
